// File: rtl/tc_io_gpio_bank.sv
// tc_io_gpio_bank: a bank of GPIO pad channels.
// Core-side requests become registered pad-cell controls (push-pull or
// open-drain, Schmitt, pulls). Raw pad inputs are synchronised and
// glitch-filtered into in_o. Accepted rising and falling edges set sticky
// write-1-to-clear pending bits, and irq_o is the OR of those bits.
//
// Handshake: this block has no valid/ready interfaces. Every input is
// sampled on every clk_i edge. irq_clr_i is a one-cycle write-1-to-clear
// strobe, and a new edge event in the same cycle wins over the clear.
module tc_io_gpio_bank #(
    parameter int NUM_PADS = 8,
    parameter int FILT_W   = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,

    // core-side output controls
    input  logic [NUM_PADS-1:0] out_i,
    input  logic [NUM_PADS-1:0] oen_i,
    input  logic [NUM_PADS-1:0] od_i,
    input  logic [NUM_PADS-1:0] cs_i,
    input  logic [NUM_PADS-1:0] pu_i,
    input  logic [NUM_PADS-1:0] pd_i,

    // input filter and interrupt configuration
    input  logic [FILT_W-1:0]   filt_thr_i,
    input  logic [NUM_PADS-1:0] irq_rise_en_i,
    input  logic [NUM_PADS-1:0] irq_fall_en_i,
    input  logic [NUM_PADS-1:0] irq_clr_i,

    // pad side
    input  logic [NUM_PADS-1:0] pad_p2c_i,
    output logic [NUM_PADS-1:0] pad_c2p_o,
    output logic [NUM_PADS-1:0] pad_c2p_en_o,
    output logic [NUM_PADS-1:0] pad_cs_o,
    output logic [NUM_PADS-1:0] pad_pu_o,
    output logic [NUM_PADS-1:0] pad_pd_o,

    // core-side input status
    output logic [NUM_PADS-1:0] in_o,
    output logic [NUM_PADS-1:0] irq_pend_o,
    output logic                irq_o
);

    // ------------------------------------------------------------------
    // Pad-cell control path
    // ------------------------------------------------------------------
    logic [NUM_PADS-1:0] c2p_d,    c2p_q;
    logic [NUM_PADS-1:0] c2p_en_d, c2p_en_q;
    logic [NUM_PADS-1:0] cs_d,     cs_q;
    logic [NUM_PADS-1:0] pu_d,     pu_q;
    logic [NUM_PADS-1:0] pd_d,     pd_q;

    // Output mode decode: open-drain only ever pulls low, so it enables the
    // driver when the data is 0 and holds the driven value at 0.
    // Conflicting pull requests cancel so the pad is never pulled both ways.
    always_comb begin
        c2p_d    = out_i & ~od_i;
        c2p_en_d = oen_i & ~(od_i & out_i);
        cs_d     = cs_i;
        pu_d     = pu_i & ~pd_i;
        pd_d     = pd_i & ~pu_i;
    end

    // Register the pad controls. Reset leaves every pad tristate with no pulls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            c2p_q    <= '0;
            c2p_en_q <= '0;
            cs_q     <= '0;
            pu_q     <= '0;
            pd_q     <= '0;
        end else begin
            c2p_q    <= c2p_d;
            c2p_en_q <= c2p_en_d;
            cs_q     <= cs_d;
            pu_q     <= pu_d;
            pd_q     <= pd_d;
        end
    end

    assign pad_c2p_o    = c2p_q;
    assign pad_c2p_en_o = c2p_en_q;
    assign pad_cs_o     = cs_q;
    assign pad_pu_o     = pu_q;
    assign pad_pd_o     = pd_q;

    // ------------------------------------------------------------------
    // Input synchroniser and glitch filter
    // ------------------------------------------------------------------
    logic [NUM_PADS-1:0]             s1_q, s2_q;
    logic [NUM_PADS-1:0]             in_d, in_q_r;
    logic [NUM_PADS-1:0][FILT_W-1:0] cnt_d, cnt_q;
    logic [NUM_PADS-1:0][FILT_W:0]   cnt_inc;
    logic [FILT_W:0]                 thr_eff;

    // Two-flop synchroniser. Nothing downstream looks at pad_p2c_i directly.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= pad_p2c_i;
            s2_q <= s1_q;
        end
    end

    // A threshold of 0 behaves like 1, so there is always at least one
    // stable cycle before a change is accepted.
    always_comb begin
        thr_eff = {1'b0, filt_thr_i};
        if (filt_thr_i == '0) begin
            thr_eff = {{FILT_W{1'b0}}, 1'b1};
        end
    end

    // The increment is one bit wider than the counter. An all-ones count
    // therefore always satisfies the compare, and the counter cannot wrap.
    for (genvar g = 0; g < NUM_PADS; g++) begin : g_inc
        assign cnt_inc[g] = {1'b0, cnt_q[g]} + {{FILT_W{1'b0}}, 1'b1};
    end

    // Per-channel filter step. The >= compare means a threshold lowered
    // mid-count is satisfied on the next mismatching cycle.
    always_comb begin
        cnt_d = cnt_q;
        in_d  = in_q_r;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (s2_q[i] == in_q_r[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_inc[i] >= thr_eff) begin
                in_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_inc[i][FILT_W-1:0];
            end
        end
    end

    // Filter state. Reset abandons any count that is in progress.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            in_q_r <= '0;
        end else begin
            cnt_q  <= cnt_d;
            in_q_r <= in_d;
        end
    end

    assign in_o = in_q_r;

    // ------------------------------------------------------------------
    // Edge detection and sticky interrupt pending bits
    // ------------------------------------------------------------------
    logic [NUM_PADS-1:0] in_dly_q;
    logic [NUM_PADS-1:0] rise, fall, irq_set;
    logic [NUM_PADS-1:0] pend_d, pend_q;

    // Edges are taken against the previous filtered value.
    // A set takes priority over a same-cycle clear.
    always_comb begin
        rise    = in_q_r & ~in_dly_q;
        fall    = ~in_q_r & in_dly_q;
        irq_set = (rise & irq_rise_en_i) | (fall & irq_fall_en_i);
        pend_d  = irq_set | (pend_q & ~irq_clr_i);
    end

    // Delayed copy of in_o and the pending register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_dly_q <= '0;
            pend_q   <= '0;
        end else begin
            in_dly_q <= in_q_r;
            pend_q   <= pend_d;
        end
    end

    assign irq_pend_o = pend_q;
    assign irq_o      = |pend_q;

endmodule

// File: tb/tb_tc_io_gpio_bank.sv
// Directed testbench for tc_io_gpio_bank.
// Inputs change on the falling edge of the clock and outputs are checked on
// later falling edges, so "N edges" means N rising edges after the change.
module tb_tc_io_gpio_bank;
  localparam int NP = 8;
  localparam int FW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NP-1:0] out_v, oen_v, od_v, cs_v, pu_v, pd_v;
  logic [FW-1:0] thr;
  logic [NP-1:0] rise_en, fall_en, clr, pad_in;
  logic [NP-1:0] c2p, c2p_en, pcs, ppu, ppd, in_v, pend;
  logic          irq;

  tc_io_gpio_bank #(.NUM_PADS(NP), .FILT_W(FW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .out_i(out_v), .oen_i(oen_v), .od_i(od_v),
    .cs_i(cs_v), .pu_i(pu_v), .pd_i(pd_v),
    .filt_thr_i(thr),
    .irq_rise_en_i(rise_en), .irq_fall_en_i(fall_en), .irq_clr_i(clr),
    .pad_p2c_i(pad_in),
    .pad_c2p_o(c2p), .pad_c2p_en_o(c2p_en), .pad_cs_o(pcs),
    .pad_pu_o(ppu), .pad_pd_o(ppd),
    .in_o(in_v), .irq_pend_o(pend), .irq_o(irq)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    out_v = '0; oen_v = '0; od_v = '0; cs_v = '0; pu_v = '0; pd_v = '0;
    thr = 4'd1; rise_en = '0; fall_en = '0; clr = '0; pad_in = '0;
    tick(2);
    check("rst_en", 32'(c2p_en), 0);
    check("rst_c2p", 32'(c2p), 0);
    check("rst_in", 32'(in_v), 0);
    check("rst_irq", 32'(irq), 0);
    rst_n = 1'b1;
    tick(1);

    // push-pull on ch0
    oen_v[0] = 1'b1; out_v[0] = 1'b1;
    #1 check("pp_not_yet", 32'(c2p_en[0]), 0);
    tick(1);
    check("pp_c2p1", 32'(c2p[0]), 1);
    check("pp_en1", 32'(c2p_en[0]), 1);
    out_v[0] = 1'b0;
    tick(1);
    check("pp_c2p0", 32'(c2p[0]), 0);
    check("pp_en0", 32'(c2p_en[0]), 1);

    // open-drain on ch0
    od_v[0] = 1'b1; out_v[0] = 1'b1;
    tick(1);
    check("od_en_hi", 32'(c2p_en[0]), 0);
    check("od_c2p_hi", 32'(c2p[0]), 0);
    out_v[0] = 1'b0;
    tick(1);
    check("od_en_lo", 32'(c2p_en[0]), 1);
    check("od_c2p_lo", 32'(c2p[0]), 0);

    // Schmitt and pulls: the bits where pu and pd are both set cancel
    cs_v = 8'h0F; pu_v = 8'h33; pd_v = 8'h55;
    tick(1);
    check("cs", 32'(pcs), 32'h0F);
    check("pu", 32'(ppu), 32'h22);
    check("pd", 32'(ppd), 32'h44);

    // filter, threshold 4: a 3-cycle pulse on ch1 is rejected
    thr = 4'd4; pad_in[1] = 1'b1;
    tick(3);
    pad_in[1] = 1'b0;
    tick(8);
    check("filt_reject", 32'(in_v[1]), 0);
    // a held level is accepted exactly 6 edges after the change
    pad_in[1] = 1'b1;
    tick(5);
    check("filt_5", 32'(in_v[1]), 0);
    tick(1);
    check("filt_6", 32'(in_v[1]), 1);
    // threshold 0 behaves as 1: accepted 3 edges after the change
    thr = 4'd0; pad_in[1] = 1'b0;
    tick(2);
    check("thr0_2", 32'(in_v[1]), 1);
    tick(1);
    check("thr0_3", 32'(in_v[1]), 0);
    // a threshold lowered mid-count is accepted on the next edge
    thr = 4'd4; pad_in[1] = 1'b1;
    tick(4);
    check("lower_before", 32'(in_v[1]), 0);
    thr = 4'd2;
    tick(1);
    check("lower_after", 32'(in_v[1]), 1);
    thr = 4'd1; pad_in[1] = 1'b0;
    tick(4);

    // IRQ on ch2, rising edges only
    rise_en[2] = 1'b1; pad_in[2] = 1'b1;
    tick(3);
    check("irq_in2", 32'(in_v[2]), 1);
    check("irq_pend_early", 32'(pend[2]), 0);
    tick(1);
    check("irq_pend2", 32'(pend[2]), 1);
    check("irq_o", 32'(irq), 1);
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0;
    check("irq_clr", 32'(pend[2]), 0);
    check("irq_o_clr", 32'(irq), 0);
    pad_in[2] = 1'b0;
    tick(4);
    check("irq_no_fall", 32'(pend[2]), 0);
    // the clear lands on the same edge as a new rise event, and the set wins
    pad_in[2] = 1'b1;
    tick(3);
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0;
    check("irq_set_wins", 32'(pend[2]), 1);

    // ch3 with falling edges only
    fall_en[3] = 1'b1; pad_in[3] = 1'b1;
    tick(4);
    check("fall_no_rise", 32'(pend[3]), 0);
    pad_in[3] = 1'b0;
    tick(3);
    check("fall_in0", 32'(in_v[3]), 0);
    check("fall_early", 32'(pend[3]), 0);
    tick(1);
    check("fall_pend", 32'(pend[3]), 1);

    // all channels rise at once
    pad_in = '0; fall_en = '0; rise_en = '1;
    tick(4);
    clr = '1;
    tick(1);
    clr = '0;
    check("all_clr", 32'(pend), 0);
    pad_in = '1;
    tick(4);
    check("all_in", 32'(in_v), 32'hFF);
    check("all_pend", 32'(pend), 32'hFF);

    // reset in the middle of a count, with the pads driving
    out_v = '1; od_v = '0; oen_v = '1; thr = 4'd4;
    tick(1);
    check("pre_rst_en", 32'(c2p_en), 32'hFF);
    pad_in = '0;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_en", 32'(c2p_en), 0);
    check("arst_c2p", 32'(c2p), 0);
    check("arst_in", 32'(in_v), 0);
    check("arst_irq", 32'(irq), 0);
    // after release, a pad held high comes through and raises a rise event
    pad_in = '1; thr = 4'd1;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_2", 32'(in_v), 0);
    tick(1);
    check("post_rst_3", 32'(in_v), 32'hFF);
    tick(1);
    check("post_rst_pend", 32'(pend), 32'hFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/tc_io_gpio_bank.md
TC_IO_GPIO_BANK -- requirements
Module: tc_io_gpio_bank

Interface
REQ-001 SHALL have parameter NUM_PADS, default 8, the number of pad channels (1..32).
REQ-002 SHALL have parameter FILT_W, default 4, the glitch-filter counter width (1..8).
REQ-003 SHALL have clk_i  in  1  single clock for all logic.
REQ-004 SHALL have rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have out_i  in  NUM_PADS  data to drive per channel.
REQ-006 SHALL have oen_i  in  NUM_PADS  output enable request, 1 = drive.
REQ-007 SHALL have od_i  in  NUM_PADS  open-drain mode select, 1 = open-drain.
REQ-008 SHALL have cs_i, pu_i, pd_i  in  NUM_PADS each  Schmitt, pull-up and pull-down requests.
REQ-009 SHALL have filt_thr_i  in  FILT_W  stable cycles required before an input change is accepted.
REQ-010 SHALL have irq_rise_en_i, irq_fall_en_i  in  NUM_PADS each  per-channel edge interrupt enables.
REQ-011 SHALL have irq_clr_i  in  NUM_PADS  one-cycle write-1-to-clear of pending bits.
REQ-012 SHALL have pad_p2c_i  in  NUM_PADS  raw asynchronous pad-to-core inputs.
REQ-013 SHALL have pad_c2p_o, pad_c2p_en_o, pad_cs_o, pad_pu_o, pad_pd_o  out  NUM_PADS each  pad-cell controls.
REQ-014 SHALL have in_o  out  NUM_PADS  filtered, synchronised input value.
REQ-015 SHALL have irq_pend_o  out  NUM_PADS  sticky pending bits; irq_o  out  1  OR of irq_pend_o.

Function
REQ-016 SHALL register all pad_*_o outputs: values appear one clk_i edge after the inputs change.
REQ-017 SHALL in push-pull mode (od_i=0) drive pad_c2p_o=out_i and pad_c2p_en_o=oen_i.
REQ-018 SHALL in open-drain mode (od_i=1) drive pad_c2p_o=0 and pad_c2p_en_o=oen_i AND NOT out_i.
REQ-019 SHALL pass cs_i/pu_i/pd_i through registered; pu_i and pd_i both 1 SHALL yield pad_pu_o=pad_pd_o=0.
REQ-020 SHALL synchronise each pad_p2c_i through two flops (s1, s2) before any other use.
REQ-021 SHALL keep per channel a counter cnt (FILT_W bits): cleared whenever s2 equals in_o.
REQ-022 SHALL when s2 differs from in_o and cnt+1 >= max(filt_thr_i,1): load in_o from s2 and clear cnt; otherwise increment cnt.
REQ-023 SHALL give latency from pad_p2c_i change to in_o of 2+max(filt_thr_i,1) edges; a pulse shorter than max(filt_thr_i,1) s2-cycles SHALL be rejected.
REQ-024 SHALL never wrap cnt; a lowered filt_thr_i mid-count SHALL accept on the next mismatching cycle (>= compare).
REQ-025 SHALL hold a registered copy in_q of in_o; rise = in_o&~in_q, fall = ~in_o&in_q.
REQ-026 SHALL set irq_pend_o[i] on (rise&irq_rise_en_i | fall&irq_fall_en_i)[i]; otherwise clear it when irq_clr_i[i]=1.
REQ-027 SHALL give set priority over clear in the same cycle; pending is set one edge after the in_o change.
REQ-028 SHALL derive irq_o combinationally from the irq_pend_o register (no extra latency).
REQ-029 SHALL treat channels fully independently; simultaneous events on all channels SHALL all be captured.

Reset
REQ-030 SHALL on rst_n_i low asynchronously force pad_c2p_o=0, pad_c2p_en_o=0 (all pads tristate), pad_cs_o=0, pad_pu_o=0, pad_pd_o=0.
REQ-031 SHALL on reset clear s1, s2, cnt, in_o, in_q, irq_pend_o; irq_o=0.
REQ-032 SHALL abandon any in-progress filter count on reset; after release a pad held high SHALL produce in_o=1 after 2+max(filt_thr_i,1) edges and a rise event if enabled.

Verification
REQ-033 Push-pull: od_i=0, oen_i=1, out_i=1 on ch0 -> pad_c2p_o[0]=1, pad_c2p_en_o[0]=1 one edge later; out_i=0 -> pad_c2p_o[0]=0.
REQ-034 Open-drain: od_i=1, oen_i=1, out_i toggling 1/0 -> pad_c2p_en_o = 0/1, pad_c2p_o always 0.
REQ-035 Filter: filt_thr_i=4, pad_p2c_i[1] high 3 cycles -> in_o[1] stays 0; high 4+ cycles -> in_o[1]=1 exactly 6 edges after change; filt_thr_i=0 -> 3 edges.
REQ-036 IRQ: irq_rise_en_i[2]=1, rise on ch2 -> irq_pend_o[2]=1, irq_o=1; irq_clr_i[2] pulse -> 0; clear coincident with new rise -> stays 1.
REQ-037 Fall-only: irq_fall_en_i[3]=1, irq_rise_en_i[3]=0, pulse 1 then 0 -> pending set only on the falling acceptance.
REQ-038 Reset mid-operation: assert rst_n_i during a count with outputs driving -> all pad_c2p_en_o=0, in_o=0, irq_o=0 immediately, no clock required.
